branch_predictor_btb: RTL and testbench

Parametrised branch target buffer with per-entry saturating direction counters and optional gshare indexing. It is the next-generation predictor behind the fetch stage. Fetch presents the PC and gets a same-cycle taken/target prediction plus the table index used. The execute/memory stage returns the resolved outcome through a single update port, which trains the table on the next clock edge.

---
 rtl/btb_pkg.sv | 13 +
 rtl/cpu_types_pkg.sv | 4 +
 rtl/branch_predictor_btb_if.sv | 34 +++
 rtl/branch_predictor_btb_sat.sv | 20 ++
 rtl/branch_predictor_btb.sv | 119 +++++++++++
 tb/tb_branch_predictor_btb.sv | 176 +++++++++++++++++
 6 files changed

// File: rtl/btb_pkg.sv
// Branch target buffer shared constants and saturating-counter helpers.
package btb_pkg;
  localparam int CTR_MAX_W = 4;
  typedef logic [CTR_MAX_W-1:0] ctr_t;

  function automatic ctr_t ctr_inc(ctr_t c, ctr_t max);
    return (c == max) ? c : c + 1'b1;
  endfunction

  function automatic ctr_t ctr_dec(ctr_t c);
    return (c == '0) ? c : c - 1'b1;
  endfunction
endpackage

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by all pipeline units.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup and resolve update bundle for the BTB predictor.
interface branch_predictor_btb_if #(
  parameter int INDEX_W = 4
) ();
  import cpu_types_pkg::*;

  word_t              lookup_pc;
  logic               predict;
  word_t              pred_target;
  logic [INDEX_W-1:0] pred_index;

  logic               upd_en;
  logic [INDEX_W-1:0] upd_index;
  word_t              upd_pc;
  logic               upd_taken;
  word_t              upd_target;

  modport bp (
    input  lookup_pc,
    output predict, pred_target, pred_index,
    input  upd_en, upd_index, upd_pc,
    input  upd_taken, upd_target
  );

  modport fetch (
    output lookup_pc,
    input  predict, pred_target, pred_index
  );

  modport resolve (
    output upd_en, upd_index, upd_pc,
    output upd_taken, upd_target
  );
endinterface

// File: rtl/branch_predictor_btb_sat.sv
// Next value of a CTR_W-bit saturating direction counter.
module sat_counter_update
  import btb_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             inc_i,
  output logic [CTR_W-1:0] ctr_o
);
  localparam ctr_t MAXV = ctr_t'((2**CTR_W) - 1);

  ctr_t wide;
  ctr_t nxt;

  assign wide  = ctr_t'(ctr_i);
  assign nxt   = inc_i ? ctr_inc(wide, MAXV)
                       : ctr_dec(wide);
  assign ctr_o = CTR_W'(nxt);
endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry direction counters and
// optional gshare indexing; lookup is combinational.
module branch_predictor_btb
  import btb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int GSHARE  = 0,
  localparam int INDEX_W = $clog2(ENTRIES)
) (
  input logic CLK,
  input logic RST,
  branch_predictor_btb_if.bp bp
);
  localparam logic [CTR_W-1:0] CTR_WNT =
    CTR_W'((2**(CTR_W-1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WT =
    CTR_W'(2**(CTR_W-1));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [29:0]      target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  entry_t tbl_q [ENTRIES];

  logic [INDEX_W-1:0] ghr;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   ltag;
  entry_t             lent;
  logic               hit;

  assign idx  = bp.lookup_pc[INDEX_W+1:2] ^ ghr;
  assign ltag = bp.lookup_pc[TAG_W+INDEX_W+1 -: TAG_W];
  assign lent = tbl_q[idx];
  assign hit  = lent.valid && (lent.tag == ltag);

  assign bp.predict     = hit && lent.ctr[CTR_W-1];
  assign bp.pred_target = bp.predict
                        ? {lent.target, 2'b00}
                        : bp.lookup_pc + 32'd4;
  assign bp.pred_index  = idx;

  logic [TAG_W-1:0] utag;
  entry_t           uent;
  entry_t           entry_d;
  logic             uhit;
  logic             wr;
  logic [CTR_W-1:0] ctr_nxt;

  assign utag = bp.upd_pc[TAG_W+INDEX_W+1 -: TAG_W];
  assign uent = tbl_q[bp.upd_index];
  assign uhit = uent.valid && (uent.tag == utag);

  sat_counter_update #(
    .CTR_W(CTR_W)
  ) u_ctr (
    .ctr_i(uent.ctr),
    .inc_i(bp.upd_taken),
    .ctr_o(ctr_nxt)
  );

  // Hits train; misses allocate only on taken outcomes.
  always_comb begin
    entry_d = uent;
    wr      = 1'b0;
    if (uhit) begin
      wr          = 1'b1;
      entry_d.ctr = ctr_nxt;
      if (bp.upd_taken)
        entry_d.target = bp.upd_target[31:2];
    end else if (bp.upd_taken) begin
      wr             = 1'b1;
      entry_d.valid  = 1'b1;
      entry_d.tag    = utag;
      entry_d.target = bp.upd_target[31:2];
      entry_d.ctr    = CTR_WT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid <= 1'b0;
        tbl_q[i].ctr   <= CTR_WNT;
      end
    end else if (bp.upd_en && wr) begin
      tbl_q[bp.upd_index] <= entry_d;
    end
  end

  generate
    if (GSHARE != 0) begin : g_ghr
      logic [INDEX_W-1:0] ghr_q;
      logic [INDEX_W-1:0] ghr_d;

      always_comb begin
        ghr_d = ghr_q;
        if (bp.upd_en)
          ghr_d = {ghr_q[INDEX_W-2:0], bp.upd_taken};
      end

      always_ff @(posedge CLK) begin
        if (RST) ghr_q <= '0;
        else     ghr_q <= ghr_d;
      end

      assign ghr = ghr_q;
    end else begin : g_no_ghr
      assign ghr = '0;
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^{bp.upd_pc, bp.upd_target[1:0]};
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench: plain-index and gshare BTB instances side by side.
module tb_branch_predictor_btb;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  branch_predictor_btb_if #(.INDEX_W(4)) i0 ();
  branch_predictor_btb_if #(.INDEX_W(4)) i1 ();

  branch_predictor_btb #(
    .ENTRIES(16), .TAG_W(8), .CTR_W(2), .GSHARE(0)
  ) u0 (
    .CLK(clk), .RST(rst), .bp(i0)
  );

  branch_predictor_btb #(
    .ENTRIES(16), .TAG_W(8), .CTR_W(2), .GSHARE(1)
  ) u1 (
    .CLK(clk), .RST(rst), .bp(i1)
  );

  typedef struct {
    bit          g;
    logic        p;
    logic [31:0] t;
    logic [3:0]  i;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Monitor: compares whenever an expectation is outstanding
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic        ap;
      logic [31:0] at;
      logic [3:0]  ai;
      e = sb.pop_front();
      if (e.g) begin
        ap = i1.predict; at = i1.pred_target;
        ai = i1.pred_index;
      end else begin
        ap = i0.predict; at = i0.pred_target;
        ai = i0.pred_index;
      end
      n_cmp++;
      if (ap !== e.p || at !== e.t || ai !== e.i) begin
        n_fail++;
        $display("FAIL %s: got p=%0b t=%h i=%0d want p=%0b t=%h i=%0d",
                 e.nm, ap, at, ai, e.p, e.t, e.i);
      end
    end
  end

  task automatic cyc(
    input bit g, input logic [31:0] pc,
    input bit ue, input logic [3:0] ui,
    input logic [31:0] upc, input bit ut,
    input logic [31:0] utg, input bit chk,
    input bit ep, input logic [31:0] et,
    input logic [3:0] ei, input string nm
  );
    exp_t e;
    i0.upd_en = 1'b0;
    i1.upd_en = 1'b0;
    if (g) begin
      i1.lookup_pc = pc; i1.upd_en = ue;
      i1.upd_index = ui; i1.upd_pc = upc;
      i1.upd_taken = ut; i1.upd_target = utg;
    end else begin
      i0.lookup_pc = pc; i0.upd_en = ue;
      i0.upd_index = ui; i0.upd_pc = upc;
      i0.upd_taken = ut; i0.upd_target = utg;
    end
    if (chk) begin
      e.g = g; e.p = ep; e.t = et; e.i = ei; e.nm = nm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(
    input bit g, input logic [31:0] pc,
    input bit ep, input logic [31:0] et,
    input logic [3:0] ei, input string nm
  );
    cyc(g, pc, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0,
        1'b1, ep, et, ei, nm);
  endtask

  task automatic upd(
    input bit g, input logic [3:0] ui,
    input logic [31:0] upc, input bit ut,
    input logic [31:0] utg
  );
    cyc(g, 32'd0, 1'b1, ui, upc, ut, utg,
        1'b0, 1'b0, 32'd0, 4'd0, "");
  endtask

  initial begin
    i0.lookup_pc = '0; i0.upd_en = 1'b0; i0.upd_index = '0;
    i0.upd_pc = '0; i0.upd_taken = 1'b0; i0.upd_target = '0;
    i1.lookup_pc = '0; i1.upd_en = 1'b0; i1.upd_index = '0;
    i1.upd_pc = '0; i1.upd_taken = 1'b0; i1.upd_target = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    look(0, 32'h40, 0, 32'h44, 0, "rst_look");
    cyc(0, 32'h40, 1, 0, 32'h40, 1, 32'h100,
        1, 0, 32'h44, 0, "hazard_same_cyc");
    look(0, 32'h40, 1, 32'h100, 0, "alloc_hit");
    look(0, 32'h440, 0, 32'h444, 0, "tag_miss");

    upd(0, 1, 32'h44, 1, 32'h200);
    look(0, 32'h44, 1, 32'h200, 1, "sat_alloc");
    repeat (3) upd(0, 1, 32'h44, 1, 32'h200);
    upd(0, 1, 32'h44, 0, 32'h0);
    look(0, 32'h44, 1, 32'h200, 1, "sat_top_nt1");
    upd(0, 1, 32'h44, 0, 32'h0);
    look(0, 32'h44, 0, 32'h48, 1, "sat_nt2");
    repeat (2) upd(0, 1, 32'h44, 0, 32'h0);
    look(0, 32'h44, 0, 32'h48, 1, "sat_floor_hold");
    repeat (3) upd(0, 1, 32'h44, 0, 32'h0);
    upd(0, 1, 32'h44, 1, 32'h300);
    look(0, 32'h44, 0, 32'h48, 1, "sat_floor_t1");
    upd(0, 1, 32'h44, 1, 32'h300);
    look(0, 32'h44, 1, 32'h300, 1, "sat_t2_target");

    upd(0, 2, 32'h48, 0, 32'h900);
    look(0, 32'h48, 0, 32'h4C, 2, "nt_no_alloc");
    look(0, 32'hFFFF_FFFC, 0, 32'h0, 15, "pc_wrap");

    look(1, 32'h4, 0, 32'h8, 1, "gs_rst_idx");
    upd(1, 10, 32'h1000, 1, 32'h700);
    upd(1, 10, 32'h1000, 1, 32'h700);
    upd(1, 10, 32'h1000, 0, 32'h700);
    look(1, 32'h4, 0, 32'h8, 7, "gs_ghr_idx");
    upd(1, 7, 32'h4, 1, 32'h500);
    look(1, 32'h28, 1, 32'h500, 7, "gs_hit");

    // Reset with updates pending on both instances
    rst = 1'b1;
    i0.upd_en = 1'b1; i0.upd_index = 3;
    i0.upd_pc = 32'h4C; i0.upd_taken = 1'b1;
    i0.upd_target = 32'h600;
    i1.upd_en = 1'b1; i1.upd_index = 7;
    i1.upd_pc = 32'h1C; i1.upd_taken = 1'b1;
    i1.upd_target = 32'h800;
    @(posedge clk);
    #1;
    rst = 1'b0;

    look(0, 32'h40, 0, 32'h44, 0, "rst_mid_e0");
    look(0, 32'h44, 0, 32'h48, 1, "rst_mid_e1");
    look(0, 32'h4C, 0, 32'h50, 3, "rst_upd_drop");
    look(1, 32'h4, 0, 32'h8, 1, "gs_rst_ghr");
    look(1, 32'h1C, 0, 32'h20, 7, "gs_rst_drop");

    for (int k = 0; k < 10 && sb.size() > 0; k++)
      @(posedge clk);
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
